// File: rtl/stream_serializer_pkg.sv
// Shared types and elaboration helpers for the width-narrowing stream serializer.
package stream_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int calc_nchunks(input int in_nbits, input int out_nbits);
    return in_nbits / out_nbits;
  endfunction

  function automatic int calc_cnt_w(input int in_nbits, input int out_nbits);
    return $clog2(in_nbits / out_nbits);
  endfunction

endpackage

// File: rtl/stream_serializer_if.sv
// val/rdy stream bundle; last is meaningful only on the narrowed output side.
interface stream_serializer_if #(
  parameter int p_nbits = 8
);
  logic               val;
  logic               rdy;
  logic [p_nbits-1:0] msg;
  logic               last;

  modport master (output val, output msg, output last, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/stream_serializer.sv
// Splits each wide input message into LSB-first chunks on a val/rdy stream,
// accepting the next message in the same cycle the final chunk departs.
module stream_serializer
  import stream_serializer_pkg::*;
#(
  parameter int p_in_nbits  = 32,
  parameter int p_out_nbits = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  stream_serializer_if.slave   istream,
  stream_serializer_if.master  ostream
);

  localparam int NCHUNKS = calc_nchunks(p_in_nbits, p_out_nbits);
  localparam int CNT_W   = calc_cnt_w(p_in_nbits, p_out_nbits);
  localparam int IDX_W   = $clog2(p_in_nbits);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNKS - 1);

  state_t                  state_q, state_d;
  logic [p_in_nbits-1:0]   msg_q, msg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        base;
  logic                    in_xfer;
  logic                    out_xfer;

  assign base         = IDX_W'(cnt_q) * IDX_W'(p_out_nbits);
  assign ostream.val  = (state_q == SEND);
  assign ostream.msg  = msg_q[base +: p_out_nbits];
  assign ostream.last = (state_q == SEND) && (cnt_q == LAST_CNT);
  // Ready looks through to downstream so a new message can land on the final chunk.
  assign istream.rdy  = reset && ((state_q == IDLE) || (ostream.last && ostream.rdy));

  assign in_xfer  = istream.val && istream.rdy;
  assign out_xfer = ostream.val && ostream.rdy;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d = state_q;
    msg_d   = msg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          msg_d   = istream.msg;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (cnt_q != LAST_CNT) begin
            cnt_d = cnt_q + 1'b1;
          end else if (in_xfer) begin
            msg_d = istream.msg;
            cnt_d = '0;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the message payload is deliberately not reset; it is only observed in SEND.
  always_ff @(posedge clk) begin
    msg_q <= msg_d;
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Scoreboard bench: stimulus pushes hand-computed chunks, monitors pop and compare.
module tb_stream_serializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_serializer_if #(.p_nbits(32)) in8 ();
  stream_serializer_if #(.p_nbits(8))  out8 ();
  stream_serializer_if #(.p_nbits(32)) in16 ();
  stream_serializer_if #(.p_nbits(16)) out16 ();

  assign in8.last  = 1'b0;
  assign in16.last = 1'b0;

  stream_serializer #(.p_in_nbits(32), .p_out_nbits(8)) dut8 (
    .clk     (clk),
    .reset   (reset),
    .istream (in8.slave),
    .ostream (out8.master)
  );

  stream_serializer #(.p_in_nbits(32), .p_out_nbits(16)) dut16 (
    .clk     (clk),
    .reset   (reset),
    .istream (in16.slave),
    .ostream (out16.master)
  );

  typedef struct {
    logic [7:0] msg;
    logic       last;
  } exp8_t;

  typedef struct {
    logic [15:0] msg;
    logic        last;
  } exp16_t;

  exp8_t  q8[$];
  exp16_t q16[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the byte-wide instance.
  always @(negedge clk) begin
    if (reset) begin
      if (q8.size() > 0) begin
        check(out8.val === 1'b1, "val8", 32'(out8.val), 32'd1);
        check(out8.msg === q8[0].msg, "msg8", 32'(out8.msg), 32'(q8[0].msg));
        check(out8.last === q8[0].last, "last8", 32'(out8.last), 32'(q8[0].last));
        if (!q8[0].last)
          check(in8.rdy === 1'b0, "irdy_busy8", 32'(in8.rdy), 32'd0);
        else if (out8.rdy)
          check(in8.rdy === 1'b1, "irdy_last8", 32'(in8.rdy), 32'd1);
        if (out8.val && out8.rdy) void'(q8.pop_front());
      end else if (out8.val !== 1'b0) begin
        check(1'b0, "spurious8", 32'(out8.msg), 32'd0);
      end
    end
  end

  // Monitor for the half-word instance.
  always @(negedge clk) begin
    if (reset) begin
      if (q16.size() > 0) begin
        check(out16.val === 1'b1, "val16", 32'(out16.val), 32'd1);
        check(out16.msg === q16[0].msg, "msg16", 32'(out16.msg), 32'(q16[0].msg));
        check(out16.last === q16[0].last, "last16", 32'(out16.last), 32'(q16[0].last));
        if (out16.val && out16.rdy) void'(q16.pop_front());
      end else if (out16.val !== 1'b0) begin
        check(1'b0, "spurious16", 32'(out16.msg), 32'd0);
      end
    end
  end

  // Offers m until accepted, then queues its hand-computed chunks; leaves val high.
  task automatic send8(input logic [31:0] m, input logic [7:0] e [4]);
    bit acc = 1'b0;
    in8.val = 1'b1;
    in8.msg = m;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (in8.rdy) acc = 1'b1;
    end
    if (!acc) begin
      check(1'b0, "accept8_timeout", m, 32'd0);
      return;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) q8.push_back('{msg: e[i], last: (i == 3)});
  endtask

  task automatic send16(input logic [31:0] m, input logic [15:0] e [2]);
    bit acc = 1'b0;
    in16.val = 1'b1;
    in16.msg = m;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (in16.rdy) acc = 1'b1;
    end
    if (!acc) begin
      check(1'b0, "accept16_timeout", m, 32'd0);
      return;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) q16.push_back('{msg: e[i], last: (i == 1)});
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      if (q8.size() == 0 && q16.size() == 0) done = 1'b1;
    end
    check(done, name, 32'(q8.size() + q16.size()), 32'd0);
  endtask

  logic bp_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    reset     = 1'b0;
    in8.val   = 1'b0;
    in8.msg   = 'x;
    out8.rdy  = 1'b1;
    in16.val  = 1'b0;
    in16.msg  = 'x;
    out16.rdy = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(in8.rdy === 1'b0, "rst_irdy", 32'(in8.rdy), 32'd0);
    check(out8.val === 1'b0, "rst_oval", 32'(out8.val), 32'd0);
    check(out8.last === 1'b0, "rst_olast", 32'(out8.last), 32'd0);
    check(in16.rdy === 1'b0, "rst_irdy16", 32'(in16.rdy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Idle input with an unknown message.
    repeat (10) begin
      @(negedge clk);
      check(out8.val === 1'b0, "idle_oval", 32'(out8.val), 32'd0);
    end
    check(in8.rdy === 1'b1, "idle_irdy", 32'(in8.rdy), 32'd1);
    @(posedge clk);
    #1;

    // Single message.
    send8(32'h44332211, '{8'h11, 8'h22, 8'h33, 8'h44});
    in8.val = 1'b0;
    in8.msg = 'x;
    drain("drain_single");
    @(negedge clk);
    check(out8.val === 1'b0, "single_done_oval", 32'(out8.val), 32'd0);
    check(in8.rdy === 1'b1, "single_done_irdy", 32'(in8.rdy), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back messages with no bubble.
    send8(32'hA3A2A1A0, '{8'hA0, 8'hA1, 8'hA2, 8'hA3});
    send8(32'hB3B2B1B0, '{8'hB0, 8'hB1, 8'hB2, 8'hB3});
    in8.val = 1'b0;
    in8.msg = 'x;
    drain("drain_b2b");

    // Backpressure on the output.
    send8(32'hDEADBEEF, '{8'hEF, 8'hBE, 8'hAD, 8'hDE});
    in8.val = 1'b0;
    in8.msg = 'x;
    for (int i = 0; i < 7; i++) begin
      out8.rdy = bp_pat[i];
      @(posedge clk);
      #1;
    end
    out8.rdy = 1'b1;
    drain("drain_bp");

    // Reset after the first chunk departs discards the rest.
    send8(32'h44332211, '{8'h11, 8'h22, 8'h33, 8'h44});
    in8.val = 1'b0;
    in8.msg = 'x;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    q8.delete();
    @(negedge clk);
    check(out8.val === 1'b0, "postrst_oval", 32'(out8.val), 32'd0);
    check(in8.rdy === 1'b1, "postrst_irdy", 32'(in8.rdy), 32'd1);
    @(posedge clk);
    #1;
    send8(32'h00000055, '{8'h55, 8'h00, 8'h00, 8'h00});
    in8.val = 1'b0;
    in8.msg = 'x;
    drain("drain_postrst");

    // 16-bit chunk variant.
    send16(32'h12345678, '{16'h5678, 16'h1234});
    in16.val = 1'b0;
    in16.msg = 'x;
    drain("drain_16");
    @(negedge clk);
    check(out16.val === 1'b0, "done16_oval", 32'(out16.val), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_serializer.md
Name: stream_serializer

Overview:
- Downstream consumer of the 32-bit val/rdy bypass-queue stage.
- Accepts one p_in_nbits message and emits it as p_in_nbits/p_out_nbits narrower chunks on a val/rdy output stream, least-significant chunk first, with a last-chunk flag.
- Used to narrow the section's 32-bit queue output onto byte-wide links.
- Full throughput: a new input message is accepted in the same cycle the final chunk of the previous message departs, so no bubble is inserted.

Parameters:
- p_in_nbits, 32, input message width.
- p_out_nbits, 8, output chunk width. p_in_nbits must be an integer multiple of p_out_nbits, with a ratio of 2 or more.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk; 0 = reset asserted.
- istream_val  input  1  input message valid.
- istream_rdy  output  1  serializer can accept a message this cycle.
- istream_msg  input  p_in_nbits  input message.
- ostream_val  output  1  output chunk valid.
- ostream_rdy  input  1  downstream accepts a chunk this cycle.
- ostream_msg  output  p_out_nbits  current chunk.
- ostream_last  output  1  high when the current chunk is the final chunk of its message; qualified by ostream_val.

Behaviour:
- Constants:
  - NCHUNKS = p_in_nbits/p_out_nbits.
  - Chunk counter width = $clog2(NCHUNKS).
- State:
  - State register: IDLE or SEND.
  - Message register msg_r, p_in_nbits wide.
  - Chunk counter cnt_r, counting 0..NCHUNKS-1.
- Reset (reset==0 at a clock edge): state=IDLE, cnt_r=0. msg_r is don't-care.
  - Outputs during and after reset: ostream_val=0, istream_rdy=0 while reset==0, ostream_last=0.
- Transfer definitions:
  - Input transfer = istream_val && istream_rdy.
  - Output transfer = ostream_val && ostream_rdy.
- Outputs (combinational from state, counter and ostream_rdy):
  - ostream_val = (state==SEND).
  - ostream_msg = msg_r[cnt_r*p_out_nbits +: p_out_nbits].
  - ostream_last = (state==SEND) && (cnt_r==NCHUNKS-1).
  - istream_rdy = reset && ((state==IDLE) || (ostream_last && ostream_rdy)).
  - istream_rdy therefore depends combinationally on ostream_rdy. ostream_val must not depend on istream_val.
- IDLE:
  - On input transfer: msg_r<=istream_msg, cnt_r<=0, go to SEND.
  - Otherwise stay in IDLE.
- SEND, output transfer with cnt_r<NCHUNKS-1: cnt_r<=cnt_r+1.
- SEND, output transfer with cnt_r==NCHUNKS-1:
  - If there is a simultaneous input transfer: msg_r<=istream_msg, cnt_r<=0, stay in SEND. This is back-to-back operation with no idle cycle.
  - Otherwise: cnt_r<=0, go to IDLE.
- SEND with ostream_rdy==0: hold all state; ostream_msg and ostream_last remain stable.
- Once ostream_val rises it stays high until the output transfer completes.
- Latency: the first chunk is valid the cycle after the input transfer; there is no combinational istream_msg to ostream_msg path.
- Steady-state throughput: one chunk per cycle with ostream_rdy held high.
- Reset mid-message: the in-flight message is discarded. ostream_val=0 from the cycle after the reset edge; no partial chunks reappear after reset deasserts.
- X-safety: istream_msg is ignored when istream_val==0.

Decomposition:
- Shared package stream_serializer_pkg holds:
  - typedef enum logic [0:0] {IDLE, SEND} state_t;
  - a localparam function computing NCHUNKS and the counter width from the two parameters.
- No sub-module is required. The chunk mux is an indexed part-select.
- A bench-level top may instantiate the existing 32-bit bypass queue ahead of this block; the serializer itself contains no queue.

Test Plan:
- Single message, 0x44332211, ostream_rdy=1 → chunks 0x11,0x22,0x33,0x44 on the four cycles after acceptance, ostream_last=1 only on 0x44; then ostream_val=0 and istream_rdy=1.
- Back-to-back: 0xA3A2A1A0 then 0xB3B2B1B0, istream_val and ostream_rdy held at 1 → 8 consecutive valid chunks A0..A3,B0..B3 with no bubble; the second message is accepted in the same cycle A3 transfers.
- Backpressure: ostream_rdy toggled 1,0,0,1,1,0,1 during message 0xDEADBEEF → chunks EF,BE,AD,DE in order; ostream_msg is stable while stalled; istream_rdy=0 until the DE transfer cycle.
- Reset mid-message: reset=0 for one cycle after chunk 0x11 transfers → ostream_val=0 the following cycle and state is IDLE; a fresh message 0x00000055 then yields 0x55,0x00,0x00,0x00.
- Idle input: istream_val=0 for 10 cycles after reset with an X on istream_msg → ostream_val stays 0 throughout.
- Parameter variant, p_out_nbits=16, message 0x12345678 → chunks 0x5678 then 0x1234, with ostream_last on 0x1234.
